// File: rtl/demux_8way_stream.sv
// 1-to-8 stream demultiplexer: each output channel is a one-entry EMPTY/FULL buffer.
// Optional per-channel delivered-byte counters are built when DEMUX_COUNT_EN is defined.
module demux_8way_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [2:0]         in_dest,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [8*WIDTH-1:0] out_data,
    output logic [7:0]         out_valid,
    input  logic [7:0]         out_ready,
    input  logic [2:0]         count_sel,
    output logic [7:0]         count_out
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } chan_state_e;

    logic [7:0] w_full;
    logic [7:0] w_load;
    logic [7:0] w_drain;
    logic       w_in_xfer;

    // A FULL destination can still accept when its consumer drains in the same cycle.
    assign in_ready  = !rst && (!w_full[in_dest] || out_ready[in_dest]);
    assign w_in_xfer = in_valid && in_ready;

`ifdef DEMUX_COUNT_EN
    logic [63:0] w_cnt_flat;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_chan
            chan_state_e      r_state;
            logic [WIDTH-1:0] r_data;

            assign w_load[gi]  = w_in_xfer && (in_dest == 3'(gi));
            assign w_drain[gi] = (r_state == ST_FULL) && out_ready[gi];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_state <= ST_EMPTY;
                    r_data  <= '0;
                end else begin
                    case (r_state)
                        ST_EMPTY: if (w_load[gi]) r_state <= ST_FULL;
                        ST_FULL:  if (w_drain[gi] && !w_load[gi]) r_state <= ST_EMPTY;
                        default:  r_state <= ST_EMPTY;
                    endcase
                    if (w_load[gi]) begin
                        r_data <= in_data;
                    end
                end
            end

            assign w_full[gi]                     = (r_state == ST_FULL);
            assign out_valid[gi]                  = (r_state == ST_FULL);
            assign out_data[gi*WIDTH +: WIDTH]    = r_data;

`ifdef DEMUX_COUNT_EN
            logic [7:0] r_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_drain[gi]) begin
                    r_cnt <= r_cnt + 8'd1;
                end
            end

            assign w_cnt_flat[gi*8 +: 8] = r_cnt;
`endif
        end
    endgenerate

`ifdef DEMUX_COUNT_EN
    assign count_out = w_cnt_flat[{count_sel, 3'b000} +: 8];
`else
    logic w_unused_count_sel;
    assign w_unused_count_sel = ^count_sel;
    assign count_out          = 8'd0;
`endif

endmodule

// File: tb/tb_demux_8way_stream.sv
// Directed bench for demux_8way_stream: a channel-occupancy model plus an in-order
// scoreboard of routed bytes, checked on every cycle with immediate assertions.
module tb_demux_8way_stream;

    localparam int WIDTH = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic [WIDTH-1:0]   in_data;
    logic [2:0]         in_dest;
    logic               in_valid;
    logic               in_ready;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ready;
    logic [2:0]         count_sel;
    logic [7:0]         count_out;

    demux_8way_stream #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_dest   (in_dest),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count_sel (count_sel),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       dest;
        logic [WIDTH-1:0] data;
    } sb_entry_t;

    sb_entry_t  sb_q[$];
    logic [7:0] m_full;
    logic [7:0] m_cnt [8];
    int         checks   = 0;
    int         failures = 0;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] exp_count(input logic [2:0] sel);
`ifdef DEMUX_COUNT_EN
        return m_cnt[sel];
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [WIDTH-1:0] lane(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    // One clock cycle with the inputs already driven: check, update model, advance.
    task automatic tick();
        logic exp_rdy;
        int   idx;
        #1;
        exp_rdy = !rst && (!m_full[in_dest] || out_ready[in_dest]);
        check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
        if (!rst) begin
            check("out_valid", {56'd0, out_valid}, {56'd0, m_full});
            check("count_out", {56'd0, count_out}, {56'd0, exp_count(count_sel)});
            for (int k = 0; k < 8; k++) begin
                if (m_full[k] && out_ready[k]) begin
                    idx = -1;
                    for (int j = 0; j < sb_q.size(); j++) begin
                        if (idx < 0 && sb_q[j].dest == 3'(k)) idx = j;
                    end
                    if (idx < 0) begin
                        check("sb_missing", 64'd1, 64'd0);
                    end else begin
                        check($sformatf("deliver_ch%0d", k), {56'd0, lane(k)}, {56'd0, sb_q[idx].data});
                        sb_q.delete(idx);
                    end
                    m_cnt[k] = m_cnt[k] + 8'd1;
                    m_full[k] = 1'b0;
                end
            end
            if (in_valid && exp_rdy) begin
                sb_q.push_back('{dest: in_dest, data: in_data});
                m_full[in_dest] = 1'b1;
            end
            $display("cycle: in_v=%0b dest=%0d data=%0h rdy=%0b out_v=%02h out_r=%02h cnt=%0d",
                     in_valid, in_dest, in_data, in_ready, out_valid, out_ready, count_out);
        end else begin
            sb_q.delete();
            m_full = '0;
            for (int k = 0; k < 8; k++) m_cnt[k] = 8'd0;
            $display("cycle: reset asserted");
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [2:0] dest, input logic [WIDTH-1:0] data);
        in_valid = 1'b1;
        in_dest  = dest;
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_dest   = '0;
        in_valid  = 1'b0;
        out_ready = '0;
        count_sel = '0;
        m_full    = '0;
        for (int k = 0; k < 8; k++) m_cnt[k] = 8'd0;
        @(negedge clk);
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        #1;
        check("rst_out_valid", {56'd0, out_valid}, 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_count", {56'd0, count_out}, 64'd0);

        // Basic routing with all consumers stalled
        for (int k = 0; k < 8; k++) send(3'(k), 8'(10 * (k + 1)));
        #1;
        check("route_valid", {56'd0, out_valid}, 64'hFF);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("route_lane%0d", k), {56'd0, lane(k)}, 64'(10 * (k + 1)));
            in_dest = 3'(k);
            #1;
            check($sformatf("route_ready%0d", k), {63'd0, in_ready}, 64'd0);
        end
        out_ready = 8'hFF;
        tick();
        out_ready = 8'h00;

        // Latency: byte visible exactly one cycle after acceptance
        send(3'd3, 8'hA5);
        #1;
        check("lat_valid3", {63'd0, out_valid[3]}, 64'd1);
        check("lat_lane3", {56'd0, lane(3)}, 64'hA5);

        // Back-to-back streaming through a full channel
        send(3'd5, 8'h55);
        out_ready = 8'b0010_0000;
        for (int v = 1; v <= 3; v++) send(3'd5, 8'(v));
        tick();
        check("b2b_empty5", {63'd0, out_valid[5]}, 64'd0);
        out_ready = 8'h00;

        // Stall isolation: ch2 blocked, ch6 still accepts
        send(3'd2, 8'h22);
        in_valid = 1'b1;
        in_dest  = 3'd2;
        in_data  = 8'h99;
        #1;
        check("stall_ready2", {63'd0, in_ready}, 64'd0);
        tick();
        check("stall_hold2", {56'd0, lane(2)}, 64'h22);
        in_dest = 3'd6;
        in_data = 8'h66;
        #1;
        check("stall_ready6", {63'd0, in_ready}, 64'd1);
        tick();
        in_valid  = 1'b0;
        out_ready = 8'b0100_0000;
        tick();
        out_ready = 8'h00;

        // Reset mid-operation with four channels full (2, 3, 0, 1)
        send(3'd0, 8'h01);
        send(3'd1, 8'h02);
        #1;
        check("pre_rst_valid", {56'd0, out_valid}, 64'h0F);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("mid_rst_valid", {56'd0, out_valid}, 64'd0);
        check("mid_rst_data", out_data, 64'd0);
        for (int k = 0; k < 8; k++) begin
            count_sel = 3'(k);
            #1;
            check($sformatf("mid_rst_cnt%0d", k), {56'd0, count_out}, 64'd0);
        end

        // Counter wrap on channel 7
        count_sel = 3'd7;
        out_ready = 8'b1000_0000;
        for (int v = 0; v < 256; v++) send(3'd7, 8'(v ^ 8'h3C));
        tick();
        #1;
`ifdef DEMUX_COUNT_EN
        check("cnt_wrap", {56'd0, count_out}, 64'd0);
`else
        check("cnt_off_wrap", {56'd0, count_out}, 64'd0);
`endif
        for (int v = 0; v < 3; v++) send(3'd7, 8'(v + 8'hE0));
        tick();
        #1;
`ifdef DEMUX_COUNT_EN
        check("cnt_plus3", {56'd0, count_out}, 64'd3);
`else
        check("cnt_off_plus3", {56'd0, count_out}, 64'd0);
`endif
        count_sel = 3'd5;
        #1;
        check("cnt_other", {56'd0, count_out}, {56'd0, exp_count(3'd5)});
        check("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
